mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port of `memory` between two requesters: the instruction-fetch path and the load/store data path.
- Serialises their requests with fixed data-priority arbitration, bounded by an anti-starvation counter.
- Steers the memory's one-cycle-latency read data back to the requester that issued the read.
- Sits between the datapath/control_unit and `memory`, so fetch and data accesses can overlap at the request level.

Parameters:
- MAX_DATA_RUN, 4, max consecutive data grants while if_req is pending before fetch is forced; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- if_req  input  1  fetch request; held with if_addr until if_gnt
- if_addr  input  ADDR_W  fetch address
- if_gnt  output  1  fetch request accepted this cycle
- if_rvalid  output  1  if_rdata valid (cycle after if_gnt)
- if_rdata  output  DATA_W  fetched instruction word
- d_req  input  1  data request; held with d_* until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_funct3  input  3  access size/sign code, passed to memory
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_gnt  output  1  data request accepted this cycle
- d_rvalid  output  1  d_rdata valid (cycle after a load grant)
- d_rdata  output  DATA_W  load data
- mem_address  output  ADDR_W  to memory address
- mem_wren  output  1  to memory write enable
- mem_funct3  output  3  to memory funct3
- mem_data_in  output  DATA_W  to memory write data
- mem_data_out  input  DATA_W  from memory; valid one cycle after address
- busy  output  1  any request pending or read in flight

Behaviour:
- Reset: async, active-high. While reset is high, all outputs except the rdata buses are 0. run_cnt = 0. Pending owner = NONE. Any in-flight read is dropped, so no rvalid fires after reset.
- Grant (combinational on inputs and state, at most one grant per cycle):
  - d_req alone -> d_gnt.
  - if_req alone -> if_gnt.
  - Both, and run_cnt < MAX_DATA_RUN -> d_gnt.
  - Both, and run_cnt == MAX_DATA_RUN -> if_gnt.
- run_cnt (4-bit, saturating at MAX_DATA_RUN):
  - Increments on d_gnt while if_req = 1.
  - Clears on if_gnt or when if_req = 0.
- Memory drive in a grant cycle:
  - mem_address = granted address.
  - mem_funct3 = d_funct3 for data; 3'b010 (word) for fetch.
  - mem_wren = d_we & d_gnt only.
  - mem_data_in = d_wdata.
- Memory drive with no grant: mem_wren = 0; address, funct3 and write data hold their last granted values.
- Read return:
  - Owner register captures IF on if_gnt, DATA on (d_gnt & ~d_we), otherwise NONE.
  - Next cycle: owner IF -> if_rvalid = 1; owner DATA -> d_rvalid = 1.
  - if_rdata and d_rdata are both wired to mem_data_out; they are meaningful only with their rvalid.
- Stores produce no rvalid; d_gnt is the completion.
- Pipelining: back-to-back grants every cycle are legal. A grant in cycle N+1 does not disturb the return of the grant in cycle N.
- A requester must not change request fields while req = 1 and gnt = 0. Behaviour on violation is undefined; verification treats it as a bench error.
- busy = if_req | d_req | (owner != NONE).
- Simultaneous events:
  - Load granted in cycle N, fetch granted in N+1 -> d_rvalid in N+1, if_rvalid in N+2.
  - A req dropping in the same cycle as a competing grant is not an error.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x1000 -> if_gnt same cycle, mem_address = 0x1000, mem_funct3 = 010; next cycle if_rvalid = 1, if_rdata = memory word at 0x1000.
- Store then load: d_we = 1, addr 0x2004, wdata 0xDEADBEEF -> d_gnt, mem_wren = 1 for exactly one cycle, no d_rvalid. Then load 0x2004 -> d_rvalid next cycle with 0xDEADBEEF.
- Contention, MAX_DATA_RUN = 4: if_req and d_req held high for 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I; each rvalid routed to the correct port.
- Back-to-back: load granted in cycle N, fetch in N+1 -> d_rvalid only in N+1, if_rvalid only in N+2, never both in the same cycle.
- Reset mid-flight: assert reset in the cycle after a load grant -> d_rvalid stays 0, all grants 0, busy 0. After release, the first request is served normally with run_cnt starting at 0.
- Idle: no requests for 5 cycles -> mem_wren = 0, busy = 0, no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data with bounded data priority and routes read returns.
module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  output logic [2:0]        mem_funct3,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);
  typedef enum logic [1:0] {NONE, OWN_IF, OWN_D} owner_t;
  localparam logic [3:0] MAX = MAX_DATA_RUN[3:0];
  owner_t owner;
  logic [3:0] run_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0] f3_q;
  logic [DATA_W-1:0] wd_q;
  logic d_win;
  always_comb begin
    d_win = d_req & (~if_req | (run_cnt < MAX));
    d_gnt = ~reset & d_win;
    if_gnt = ~reset & if_req & ~d_win;
    mem_address = reset ? '0 : d_gnt ? d_addr : if_gnt ? if_addr : addr_q;
    mem_funct3 = reset ? 3'b000 : d_gnt ? d_funct3 : if_gnt ? 3'b010 : f3_q;
    mem_data_in = reset ? '0 : (d_gnt | if_gnt) ? d_wdata : wd_q;
    mem_wren = d_gnt & d_we;
    busy = ~reset & (if_req | d_req | (owner != NONE));
    if_rvalid = owner == OWN_IF;
    d_rvalid = owner == OWN_D;
    if_rdata = mem_data_out;
    d_rdata = mem_data_out;
  end
  // Held drive values track the muxed outputs, which equal the last grant when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= NONE;
      run_cnt <= '0;
      addr_q <= '0;
      f3_q <= '0;
      wd_q <= '0;
    end else begin
      owner <= if_gnt ? OWN_IF : (d_gnt & ~d_we) ? OWN_D : NONE;
      run_cnt <= (if_gnt | ~if_req) ? 4'd0 : (d_gnt && run_cnt < MAX) ? run_cnt + 4'd1 : run_cnt;
      addr_q <= mem_address;
      f3_q <= mem_funct3;
      wd_q <= mem_data_in;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural one-cycle-latency memory.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [2:0] d_funct3, mem_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic mem_wren, busy;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic [31:0] if_q [$];
  logic [31:0] d_q [$];
  int pass_n = 0;
  int total_n = 0;

  mem_port_arbiter #(.MAX_DATA_RUN(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_funct3(mem_funct3),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) mem[mem_address[9:2]] <= mem_data_in;
    mem_data_out <= mem[mem_address[9:2]];
  end

  // Returns are compared before this cycle's grants are queued, keeping FIFO order.
  always @(negedge clk) begin
    if (!reset) begin
      if (if_rvalid) begin
        total_n++;
        if (if_q.size() == 0) $display("FAIL if_rvalid_unexpected got rvalid=1 want no return pending");
        else begin
          logic [31:0] e;
          e = if_q.pop_front();
          if (if_rdata !== e) $display("FAIL if_rdata got %h want %h", if_rdata, e);
          else pass_n++;
        end
      end
      if (d_rvalid) begin
        total_n++;
        if (d_q.size() == 0) $display("FAIL d_rvalid_unexpected got rvalid=1 want no return pending");
        else begin
          logic [31:0] e;
          e = d_q.pop_front();
          if (d_rdata !== e) $display("FAIL d_rdata got %h want %h", d_rdata, e);
          else pass_n++;
        end
      end
      if (if_gnt) if_q.push_back(shadow[if_addr[9:2]]);
      if (d_gnt && d_we) shadow[d_addr[9:2]] = d_wdata;
      if (d_gnt && !d_we) d_q.push_back(shadow[d_addr[9:2]]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b1;
    d_funct3 = 3'b010; d_addr = 32'h20; d_wdata = 32'h1234;
    repeat (2) @(posedge clk);
    #4;
    total_n++;
    if ({if_gnt, d_gnt} !== 2'b00) $display("FAIL rst_gnt got %b want 00", {if_gnt, d_gnt});
    else pass_n++;
    total_n++;
    if ({mem_wren, busy, if_rvalid, d_rvalid} !== 4'b0) $display("FAIL rst_ctl got %b want 0000", {mem_wren, busy, if_rvalid, d_rvalid});
    else pass_n++;
    total_n++;
    if ({mem_address, mem_funct3, mem_data_in} !== 67'b0) $display("FAIL rst_mem got %h/%b/%h want 0", mem_address, mem_funct3, mem_data_in);
    else pass_n++;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fetch_only();
    tick();
    if_req = 1'b1; if_addr = 32'h1000;
    #3;
    total_n++;
    if ({if_gnt, d_gnt} !== 2'b10) $display("FAIL fetch_gnt got %b want 10", {if_gnt, d_gnt});
    else pass_n++;
    total_n++;
    if (mem_address !== 32'h1000 || mem_funct3 !== 3'b010) $display("FAIL fetch_drive got %h/%b want 00001000/010", mem_address, mem_funct3);
    else pass_n++;
    tick();
    if_req = 1'b0;
    #3;
    total_n++;
    if (if_rvalid !== 1'b1) $display("FAIL fetch_rvalid got %b want 1", if_rvalid);
    else pass_n++;
  endtask

  task automatic test_store_load();
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
    #3;
    total_n++;
    if (d_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_data_in !== 32'hDEADBEEF) $display("FAIL store_drive got gnt=%b wren=%b wd=%h want 1/1/deadbeef", d_gnt, mem_wren, mem_data_in);
    else pass_n++;
    tick();
    d_req = 1'b0; d_we = 1'b0;
    #3;
    total_n++;
    if (mem_wren !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL store_after got wren=%b rvalid=%b want 0/0", mem_wren, d_rvalid);
    else pass_n++;
    total_n++;
    if (mem_address !== 32'h2004 || mem_data_in !== 32'hDEADBEEF) $display("FAIL idle_hold got %h/%h want 00002004/deadbeef", mem_address, mem_data_in);
    else pass_n++;
    tick();
    d_req = 1'b1; d_addr = 32'h2004;
    #3;
    total_n++;
    if (d_gnt !== 1'b1 || mem_wren !== 1'b0) $display("FAIL load_gnt got gnt=%b wren=%b want 1/0", d_gnt, mem_wren);
    else pass_n++;
    tick();
    d_req = 1'b0;
    #3;
    total_n++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) $display("FAIL load_data got rvalid=%b data=%h want 1/deadbeef", d_rvalid, d_rdata);
    else pass_n++;
  endtask

  task automatic test_contention();
    for (int i = 0; i < 10; i++) begin
      tick();
      if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_funct3 = 3'b100;
      #3;
      total_n++;
      if ((i % 5 == 4) ? ({if_gnt, d_gnt} !== 2'b10) : ({if_gnt, d_gnt} !== 2'b01))
        $display("FAIL contention_%0d got if/d=%b want %s", i, {if_gnt, d_gnt}, (i % 5 == 4) ? "10" : "01");
      else pass_n++;
      if (i == 0) begin
        total_n++;
        if (mem_funct3 !== 3'b100 || mem_address !== 32'h200) $display("FAIL contention_drive got %b/%h want 100/00000200", mem_funct3, mem_address);
        else pass_n++;
      end
    end
    tick();
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    #3;
    total_n++;
    if (d_gnt !== 1'b1) $display("FAIL b2b_load_gnt got %b want 1", d_gnt);
    else pass_n++;
    tick();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h304;
    #3;
    total_n++;
    if ({if_gnt, d_rvalid, if_rvalid} !== 3'b110) $display("FAIL b2b_n1 got gnt/drv/irv=%b want 110", {if_gnt, d_rvalid, if_rvalid});
    else pass_n++;
    tick();
    if_req = 1'b0;
    #3;
    total_n++;
    if ({d_rvalid, if_rvalid} !== 2'b01) $display("FAIL b2b_n2 got drv/irv=%b want 01", {d_rvalid, if_rvalid});
    else pass_n++;
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 2; i++) begin
      tick();
      if_req = 1'b1; if_addr = 32'h30C; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h308;
      #3;
      total_n++;
      if (d_gnt !== 1'b1) $display("FAIL mid_pre_%0d got d_gnt=%b want 1", i, d_gnt);
      else pass_n++;
    end
    tick();
    reset = 1'b1;
    #3;
    total_n++;
    if ({d_rvalid, if_gnt, d_gnt, busy} !== 4'b0) $display("FAIL mid_reset got drv/ig/dg/busy=%b want 0000", {d_rvalid, if_gnt, d_gnt, busy});
    else pass_n++;
    if_q.delete();
    d_q.delete();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #3;
      total_n++;
      if ((i == 4) ? ({if_gnt, d_gnt} !== 2'b10) : ({if_gnt, d_gnt} !== 2'b01))
        $display("FAIL mid_post_%0d got if/d=%b want %s", i, {if_gnt, d_gnt}, (i == 4) ? "10" : "01");
      else pass_n++;
    end
    tick();
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_idle();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      #3;
      total_n++;
      if ({mem_wren, busy, if_rvalid, d_rvalid} !== 4'b0) $display("FAIL idle_%0d got wren/busy/irv/drv=%b want 0000", i, {mem_wren, busy, if_rvalid, d_rvalid});
      else pass_n++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i * 32'h01000193) ^ 32'hC0DE0000;
      shadow[i] = (i * 32'h01000193) ^ 32'hC0DE0000;
    end
    test_reset();
    test_fetch_only();
    test_store_load();
    test_contention();
    test_back_to_back();
    test_reset_midflight();
    test_idle();
    total_n++;
    if (if_q.size() != 0 || d_q.size() != 0) $display("FAIL drain got if_q=%0d d_q=%0d want 0/0", if_q.size(), d_q.size());
    else pass_n++;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
